// File: rtl/ttl_fifo_534_if.sv
// ttl_fifo_534_if
// Groups the write side, read request, output enable and status lines of
// ttl_fifo_534. The tri-state Q bus is not part of this interface. It stays a
// plain inout on the FIFO so that it can be resolved on a shared board-level net.
//
// Signals
//   D       write data                     (master -> slave)
//   WR_n    write request, active low      (master -> slave)
//   RD_n    read request, active low       (master -> slave)
//   OE_n    output enable, active low      (master -> slave)
//   EMPTY   no words stored                (slave -> master)
//   FULL    DEPTH words stored             (slave -> master)
//   COUNT   stored word count, 0..DEPTH    (slave -> master)
//   OVF     sticky overflow                (slave -> master)
//   UNF     sticky underflow               (slave -> master)

interface ttl_fifo_534_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] D;
    logic             WR_n;
    logic             RD_n;
    logic             OE_n;
    logic             EMPTY;
    logic             FULL;
    logic [CW-1:0]    COUNT;
    logic             OVF;
    logic             UNF;

    modport master (
        output D, WR_n, RD_n, OE_n,
        input  EMPTY, FULL, COUNT, OVF, UNF
    );

    modport slave (
        input  D, WR_n, RD_n, OE_n,
        output EMPTY, FULL, COUNT, OVF, UNF
    );
endinterface

// File: rtl/ttl_fifo_534.sv
// ttl_fifo_534
// Clocked FIFO that feeds a tri-state output register. The register is loaded
// only by an accepted read. It is driven onto Q, inverted when INVERT=1, and
// only while OE_n is low. The sticky OVF and UNF flags record a write that was
// refused while the FIFO was full and a read that was refused while it was
// empty. Only RST clears them.
//
// Ports
//   CK    clock; all state changes on its rising edge
//   RST   asynchronous active-high reset
//   bus   ttl_fifo_534_if.slave: D, WR_n, RD_n, OE_n in; EMPTY, FULL,
//         COUNT, OVF, UNF out
//   Q     tri-state output bus, WIDTH bits
//
// Parameters
//   WIDTH   data width, 1..32
//   DEPTH   depth in words, power of two, 2..256
//   INVERT  1: Q = ~r (LS534 behaviour), 0: Q = r (LS374 behaviour)

module ttl_fifo_534 #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter bit INVERT = 1'b0
) (
    input  logic                CK,
    input  logic                RST,
    ttl_fifo_534_if.slave       bus,
    inout  wire  [WIDTH-1:0]    Q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             full;
    logic             empty;
    logic             wr_req;
    logic             rd_req;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] q_drv;

    // Status comes from the registered count only, so that it settles straight
    // after an edge or an asynchronous reset.
    assign full   = (count_q == COUNT_FULL);
    assign empty  = (count_q == '0);
    assign wr_req = !bus.WR_n;
    assign rd_req = !bus.RD_n;

    // When the FIFO is full, a read in the same cycle frees a slot, so the
    // write is still taken. When it is empty, the read is refused even if a
    // write arrives in the same cycle.
    assign rd_acc = rd_req && !empty;
    assign wr_acc = wr_req && (!full || rd_acc);

    always_comb begin
        mem_d = mem_q;
        if (wr_acc) begin
            mem_d[wp_q] = bus.D;
        end
    end

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        if (wr_acc) begin
            wp_d = wp_q + 1'b1;
        end

        // r_d is read from mem_q, not mem_d, so a same-index write in the
        // full case cannot affect it and the read returns the old word.
        if (rd_acc) begin
            rp_d = rp_q + 1'b1;
            r_d  = mem_q[rp_q];
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (wr_req && !wr_acc) begin
            ovf_d = 1'b1;
        end
        if (rd_req && empty) begin
            unf_d = 1'b1;
        end
    end

    // Storage has no reset. A reset returns the pointers and the count to
    // zero, and that is enough to discard every stored word.
    always_ff @(posedge CK) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.EMPTY = empty;
    assign bus.FULL  = full;
    assign bus.COUNT = count_q;
    assign bus.OVF   = ovf_q;
    assign bus.UNF   = unf_q;

    // OE_n gates Q combinationally and is never sampled by CK.
    assign q_drv = INVERT ? ~r_q : r_q;
    assign Q     = bus.OE_n ? {WIDTH{1'bz}} : q_drv;

endmodule

// File: doc/ttl_fifo_534.md
# ttl_fifo_534

Parametrised clocked FIFO with a tri-state output register: the next generation of the octal D flip-flop / tri-state bus driver parts in the TTL library. It adds configurable width and depth, optional inverting outputs (LS534 vs LS374 behaviour), an asynchronous reset, full/empty status and sticky error flags. It sits between a CPU or peripheral data source and a shared tri-state bus, buffering words and driving the bus only under `OE_n`.

## Interface
- `WIDTH`, 8: data word width in bits, 1 to 32.
- `DEPTH`, 16: FIFO depth in words; power of two, 2 to 256.
- `INVERT`, 0: 1 drives `~r` onto `Q` (LS534 mode); 0 drives `r` (LS374 mode).
- `CK` input 1: single clock; all state changes on the rising edge.
- `RST` input 1: reset, asynchronous and active-high.
- `D` input `WIDTH`: write data.
- `WR_n` input 1: write request, active low, sampled at `CK`.
- `RD_n` input 1: read request, active low, sampled at `CK`; loads the output register.
- `OE_n` input 1: output enable, active low, asynchronous, combinational to `Q`.
- `Q` inout `WIDTH`: tri-state output bus.
- `EMPTY` output 1: no words stored.
- `FULL` output 1: `DEPTH` words stored.
- `COUNT` output `$clog2(DEPTH)+1`: number of stored words, 0 to `DEPTH`.
- `OVF` output 1: sticky overflow flag; a write was attempted while full.
- `UNF` output 1: sticky underflow flag; a read was attempted while empty.

## Operation
- Storage: `DEPTH` x `WIDTH` array. Write pointer and read pointer are each `$clog2(DEPTH)` bits and wrap from `DEPTH-1` to 0. `COUNT` is tracked separately.
- Write accepted = `!WR_n && !FULL`, or `!WR_n && FULL && rd_acc`. On acceptance: `mem[wp] <= D`, `wp++`.
- Read accepted (`rd_acc`) = `!RD_n && !EMPTY`. On acceptance: `r <= mem[rp]`, `rp++`.
- `COUNT` update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Simultaneous read and write:
  - When empty: the write is accepted, the read is rejected, `UNF` is set, and `r` holds.
  - When full: both are accepted; `COUNT` stays at `DEPTH`.
- Rejected write (`!WR_n`, full, no read accepted): data is dropped, pointers hold, `OVF <= 1`.
- Rejected read (`!RD_n`, empty): `r` holds, `UNF <= 1`.
- `OVF` and `UNF` clear only on `RST`.
- Output register `r` changes only on an accepted read; it holds otherwise, including while `OE_n` is high.
- `Q = !OE_n ? (INVERT ? ~r : r) : 'z`.
- `FULL = (COUNT == DEPTH)`, `EMPTY = (COUNT == 0)`. Both are derived combinationally from the registered `COUNT`.

## Timing
- Reset (asynchronous assert, synchronous-to-`CK` release):
  - `wp`, `rp`, `COUNT` = 0; `r` = 0; `EMPTY` = 1; `FULL` = 0; `OVF` = 0; `UNF` = 0.
  - `Q` = 0 (all ones if `INVERT`) when `OE_n` is low, else high-Z.
- `RST` asserted mid-operation discards all stored words immediately. Requests sampled on the first edge after release are honoured normally.
- Write-to-`EMPTY` deassert: 1 cycle (visible after the accepting edge).
- Write-to-readable: a word written at edge N can be read at edge N+1. It appears in `r` and on `Q` after edge N+1.
- Read latency: `RD_n` sampled low at edge N puts the word on `Q` after edge N, plus combinational `OE_n` gating.
- `OE_n` to `Q`: purely combinational, no clock involvement.
- Memory is a register array with no read-during-write hazard. On a simultaneous read/write to the same index (full case), the read returns the old word.

## Test plan
- Reset and idle:
  - `RST` pulse with `OE_n`=0, `INVERT`=0 -> `Q`=0x00, `EMPTY`=1, `FULL`=0, `COUNT`=0, flags 0.
  - With `OE_n`=1 -> `Q`=zz.
- Ordered transfer: write 0x11, 0x22, 0x33 on consecutive cycles, then read three times -> `Q` shows 0x11, 0x22, 0x33 on successive cycles; `COUNT` goes 3 -> 0; `EMPTY` returns to 1.
- Full, overflow and wrap (`DEPTH`=16):
  - Write 16 words 0x00..0x0F -> `FULL`=1, `COUNT`=16.
  - 17th write of 0xAA -> dropped, `OVF`=1.
  - Read 16 words -> 0x00..0x0F; write/read 20 more -> pointer wrap is correct.
- Simultaneous events:
  - Read and write on an empty FIFO -> `UNF`=1, `COUNT`=1, `r` unchanged.
  - Read and write on a full FIFO -> `COUNT` stays 16; `Q` gets the oldest word.
- Invert mode: `INVERT`=1, write 0x5A then read, `OE_n`=0 -> `Q`=0xA5. Toggle `OE_n` to 1 -> `Q`=zz, and `r` is retained when re-enabled.
- Reset mid-operation: with 5 words stored, assert `RST` between edges -> `EMPTY`=1 and `COUNT`=0 immediately, before the next edge; a subsequent read returns nothing and sets `UNF`.
